// File: rtl/dot_post_pack_if.sv
// Result-word handshake between dot_post_pack (master) and its consumer (slave).
// valid/ready: a word transfers on a clock edge where out_valid and out_ready are both 1; once raised, out_valid and out_vec hold until that transfer.
interface dot_post_pack_if #(
  parameter int LANES = 16
) ();
  logic [LANES*16-1:0] out_vec;
  logic                out_valid;
  logic                out_ready;

  modport master (output out_vec, output out_valid, input out_ready);
  modport slave  (input out_vec, input out_valid, output out_ready);
endinterface

// File: rtl/dot_post_pack.sv
// Sums CHUNKS partial dot products per neuron, adds bias, optional ReLU, saturates to Q4.11,
// and packs LANES neuron results into one handshaked output word.
module dot_post_pack #(
  parameter int CHUNKS  = 4,
  parameter int LANES   = 16,
  parameter bit RELU_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] dot_in,
  input  logic        dot_done,
  input  logic [15:0] bias_in,
  output logic        pe_rst,
  output logic [3:0]  lane_idx,
  output logic        ovf_err,
  output logic [1:0]  state_dbg,
  dot_post_pack_if.master obus
);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_POST = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic                done_q;
  logic                pend;
  logic [15:0]         pend_val;
  logic signed [23:0]  acc;
  logic [4:0]          chunk_cnt;
  logic [LANES*16-1:0] vec_q;

  logic                dn_edge;
  logic                take;
  logic [15:0]         src;
  logic signed [23:0]  acc_sum;
  logic signed [23:0]  r_sum;
  logic [15:0]         lane_val;

  always_comb begin
    dn_edge  = dot_done & ~done_q;
    take     = (state == S_WAIT) && (dn_edge || pend);
    // A pended capture is always older than a live edge, so it is consumed first.
    src      = pend ? pend_val : dot_in;
    acc_sum  = acc + {{8{src[15]}}, src};
    r_sum    = acc + {{8{bias_in[15]}}, bias_in};
    if (RELU_EN && (r_sum < 24'sd0))      lane_val = 16'h0000;
    else if (r_sum > 24'sd32767)          lane_val = 16'h7fff;
    else if (r_sum < -24'sd32768)         lane_val = 16'h8000;
    else                                  lane_val = r_sum[15:0];

    state_nx = state;
    case (state)
      S_WAIT:  if (take && (chunk_cnt == 5'(CHUNKS - 1))) state_nx = S_POST;
      S_POST:  state_nx = (lane_idx == 4'(LANES - 1)) ? S_OUT : S_WAIT;
      S_OUT:   if (obus.out_ready) state_nx = S_WAIT;
      default: state_nx = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_WAIT;
      done_q    <= 1'b0;
      pend      <= 1'b0;
      pend_val  <= 16'h0000;
      acc       <= 24'sd0;
      chunk_cnt <= 5'd0;
      vec_q     <= '0;
      lane_idx  <= 4'd0;
      pe_rst    <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= dot_done;
      pe_rst <= 1'b0;

      if (state == S_WAIT) begin
        if (take) begin
          acc       <= acc_sum;
          chunk_cnt <= chunk_cnt + 5'd1;
          pend      <= pend & dn_edge;
        end
        // A live edge that arrives while the pend slot is being drained refills the slot.
        if (pend && dn_edge) pend_val <= dot_in;
        if (dn_edge) pe_rst <= 1'b1;
      end else if (dn_edge) begin
        if (!pend) begin
          pend     <= 1'b1;
          pend_val <= dot_in;
          pe_rst   <= 1'b1;
        end else begin
          ovf_err <= 1'b1;
        end
      end

      if (state == S_POST) begin
        vec_q[16*lane_idx +: 16] <= lane_val;
        acc       <= 24'sd0;
        chunk_cnt <= 5'd0;
        if (lane_idx != 4'(LANES - 1)) lane_idx <= lane_idx + 4'd1;
      end

      if ((state == S_OUT) && obus.out_ready) lane_idx <= 4'd0;
    end
  end

  assign obus.out_vec   = vec_q;
  assign obus.out_valid = (state == S_OUT);
  assign state_dbg      = state;

endmodule

// File: tb/tb_dot_post_pack.sv
// Directed bench for dot_post_pack: a ReLU instance and a pass-through instance share one stimulus stream.
module tb_dot_post_pack;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] dot_in = 16'h0000;
  logic        dot_done = 1'b0;
  logic [15:0] bias_in = 16'h0000;
  logic        out_ready = 1'b1;

  logic        pe_rst_a, pe_rst_b, ovf_a, ovf_b;
  logic [3:0]  lane_a, lane_b;
  logic [1:0]  st_a, st_b;

  dot_post_pack_if #(.LANES(16)) bus_a ();
  dot_post_pack_if #(.LANES(16)) bus_b ();
  assign bus_a.out_ready = out_ready;
  assign bus_b.out_ready = out_ready;

  dot_post_pack #(.CHUNKS(4), .LANES(16), .RELU_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .dot_in(dot_in), .dot_done(dot_done), .bias_in(bias_in),
    .pe_rst(pe_rst_a), .lane_idx(lane_a), .ovf_err(ovf_a), .state_dbg(st_a), .obus(bus_a)
  );

  dot_post_pack #(.CHUNKS(4), .LANES(16), .RELU_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .dot_in(dot_in), .dot_done(dot_done), .bias_in(bias_in),
    .pe_rst(pe_rst_b), .lane_idx(lane_b), .ovf_err(ovf_b), .state_dbg(st_b), .obus(bus_b)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // handshake / pulse monitor, sampled on the inactive edge
  int            hs_a = 0, hs_b = 0, pe_a = 0, pe_b = 0;
  logic [255:0]  word_a = '0, word_b = '0;

  always @(negedge clk) begin
    if (bus_a.out_valid && bus_a.out_ready) begin hs_a++; word_a = bus_a.out_vec; end
    if (bus_b.out_valid && bus_b.out_ready) begin hs_b++; word_b = bus_b.out_vec; end
    if (pe_rst_a) pe_a++;
    if (pe_rst_b) pe_b++;
  end

  // scoreboard
  logic [15:0] exp_qa[$];
  logic [15:0] exp_qb[$];
  int n_checks = 0, n_pass = 0, n_fail = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input logic [15:0] va, input logic [15:0] vb);
    repeat (16) begin exp_qa.push_back(va); exp_qb.push_back(vb); end
  endtask

  task automatic check_words(input string tag);
    logic [255:0] ea, eb;
    for (int k = 0; k < 16; k++) begin
      ea[16*k +: 16] = (exp_qa.size() > 0) ? exp_qa.pop_front() : 16'hxxxx;
      eb[16*k +: 16] = (exp_qb.size() > 0) ? exp_qb.pop_front() : 16'hxxxx;
    end
    check({tag, "_a"}, word_a, ea);
    check({tag, "_b"}, word_b, eb);
  endtask

  // drivers
  task automatic edge_pulse(input logic [15:0] v);
    @(negedge clk); dot_in = v; dot_done = 1'b1;
    @(negedge clk); dot_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_lane(input logic [15:0] v);
    repeat (4) edge_pulse(v);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk); #1 out_ready = v;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!bus_a.out_valid && n < 20) begin @(negedge clk); n++; end
    check(tag, bus_a.out_valid, 1);
  endtask

  task automatic run_word(input string tag, input logic [15:0] v, input logic [15:0] b,
                          input logic [15:0] ea, input logic [15:0] eb);
    int hs0;
    hs0 = hs_a;
    bias_in = b;
    repeat (16) send_lane(v);
    expect_word(ea, eb);
    repeat (2) @(negedge clk);
    check({tag, "_hs"}, hs_a - hs0, 1);
    check_words(tag);
  endtask

  int lat, hs0, pe0;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_pe_rst", pe_rst_a, 0);
    check("rst_out_valid", bus_a.out_valid, 0);
    check("rst_out_vec", bus_a.out_vec, 0);
    check("rst_lane_idx", lane_a, 0);
    check("rst_ovf_err", ovf_a, 0);
    check("rst_state", st_a, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // accumulate + bias: 4 x 1.0 + 0.5 = 4.5 -> 0x2400, with output latency
    hs0 = hs_a; pe0 = pe_a;
    bias_in = 16'h0400;
    repeat (15) send_lane(16'h0800);
    repeat (3) edge_pulse(16'h0800);
    @(negedge clk); dot_in = 16'h0800; dot_done = 1'b1; lat = 0;
    while (!bus_a.out_valid && lat < 8) begin @(negedge clk); dot_done = 1'b0; lat++; end
    check("latency", lat, 2);
    dot_done = 1'b0;
    expect_word(16'h2400, 16'h2400);
    repeat (2) @(negedge clk);
    check("acc_hs", hs_a - hs0, 1);
    check_words("acc");
    check("acc_pe_pulses", pe_a - pe0, 64);
    check("acc_lane_idx_back", lane_a, 0);
    check("acc_valid_low", bus_a.out_valid, 0);

    // ReLU vs pass-through on -1.0 x 4
    run_word("relu", 16'hf800, 16'h0000, 16'h0000, 16'he000);
    // saturation high and low
    run_word("sat_hi", 16'h7000, 16'h7fff, 16'h7fff, 16'h7fff);
    run_word("sat_lo", 16'h8000, 16'h0000, 16'h0000, 16'h8000);

    // backpressure: pend one edge, drop a second, then a single handshake
    set_ready(1'b0);
    hs0 = hs_a;
    bias_in = 16'h0000;
    repeat (16) send_lane(16'h0800);
    expect_word(16'h2000, 16'h2000);
    wait_valid("bp_valid");
    pe0 = pe_a;
    edge_pulse(16'h0100);
    check("bp_pend_pe", pe_a - pe0, 1);
    check("bp_no_ovf_yet", ovf_a, 0);
    edge_pulse(16'h0200);
    repeat (4) @(negedge clk);
    check("bp_valid_held", bus_a.out_valid, 1);
    check("bp_vec_stable", bus_a.out_vec, {16{16'h2000}});
    check("bp_ovf_a", ovf_a, 1);
    check("bp_ovf_b", ovf_b, 1);
    check("bp_no_hs", hs_a - hs0, 0);
    set_ready(1'b1);
    repeat (3) @(negedge clk);
    check("bp_one_hs", hs_a - hs0, 1);
    check("bp_valid_drop", bus_a.out_valid, 0);
    check_words("bp");

    // pended 0x0100 opens lane 0; lane k then gets k*0x10 four times
    hs0 = hs_a;
    repeat (3) edge_pulse(16'h0800);
    exp_qa.push_back(16'h1900); exp_qb.push_back(16'h1900);
    for (int k = 1; k < 16; k++) begin
      send_lane(16'(k * 16'h0010));
      exp_qa.push_back(16'(k * 16'h0040));
      exp_qb.push_back(16'(k * 16'h0040));
    end
    repeat (2) @(negedge clk);
    check("mix_hs", hs_a - hs0, 1);
    check_words("mix");

    // reset mid-word
    hs0 = hs_a;
    bias_in = 16'h0400;
    repeat (5) send_lane(16'h0800);
    @(negedge clk); rst = 1'b0;
    #1;
    check("mid_rst_pe_rst", pe_rst_a, 0);
    check("mid_rst_valid", bus_a.out_valid, 0);
    check("mid_rst_vec", bus_a.out_vec, 0);
    check("mid_rst_lane", lane_a, 0);
    check("mid_rst_ovf_a", ovf_a, 0);
    check("mid_rst_ovf_b", ovf_b, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    // level, not edge: a 20-cycle high dot_done is a single capture
    pe0 = pe_a;
    dot_in = 16'h0800; dot_done = 1'b1;
    repeat (20) @(negedge clk);
    dot_done = 1'b0;
    repeat (2) @(negedge clk);
    check("level_pe", pe_a - pe0, 1);
    repeat (3) edge_pulse(16'h0800);
    repeat (15) send_lane(16'h0800);
    expect_word(16'h2400, 16'h2400);
    repeat (2) @(negedge clk);
    check("post_rst_hs", hs_a - hs0, 1);
    check_words("post_rst");
    check("post_rst_ovf", ovf_a, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
